// File: rtl/prbs_pkg.sv
// prbs_pkg: PRBS15 polynomial definition and checker state type, shared by generator and checker.
package prbs_pkg;
  localparam int PRBS15_LEN = 15;
  localparam int TAP_A = 14;
  localparam int TAP_B = 15;
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} chk_state_t;
  function automatic logic [3:0] popcount8(input logic [7:0] x);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 = popcount8 + {3'b000, x[i]};
  endfunction
endpackage

// File: rtl/prbs15_step8.sv
// prbs15_step8: unrolls the PRBS15 recurrence 8 times; state bit 0 is the newest bit, byte bit 7 the oldest.
module prbs15_step8
  import prbs_pkg::*;
(
  input  logic [PRBS15_LEN-1:0] state_i,
  output logic [7:0]            byte_o,
  output logic [PRBS15_LEN-1:0] state_o
);
  always_comb begin
    state_o = state_i;
    byte_o = '0;
    for (int i = 0; i < 8; i++) begin
      byte_o[7-i] = state_o[TAP_A-1] ^ state_o[TAP_B-1];
      state_o = {state_o[PRBS15_LEN-2:0], byte_o[7-i]};
    end
  end
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS15 byte checker with lock detection and saturating BER counters.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 4,
  parameter int ERR_W      = 16,
  parameter int BYTE_W     = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              en,
  input  logic [7:0]        din,
  input  logic              clear,
  output logic              locked,
  output logic              byte_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [BYTE_W-1:0] byte_cnt
);
  chk_state_t state_q, state_d;
  logic [PRBS15_LEN-1:0] lfsr_q, lfsr_d, lfsr_adv, seed;
  logic phase_q, phase_d, berr_q, berr_d;
  logic [7:0] run_q, run_d, bad_q, bad_d, pred;
  logic [ERR_W-1:0] err_q, err_d;
  logic [BYTE_W-1:0] bcnt_q, bcnt_d;
  logic [3:0] pc;
  logic [ERR_W+3:0] err_sum;

  prbs15_step8 u_step (.state_i(lfsr_q), .byte_o(pred), .state_o(lfsr_adv));

  assign pc = popcount8(din ^ pred);
  assign seed = {lfsr_q[6:0], din};
  assign err_sum = {4'b0000, err_q} + {{ERR_W{1'b0}}, pc};

  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    phase_d = phase_q;
    run_d = run_q;
    bad_d = bad_q;
    err_d = err_q;
    bcnt_d = bcnt_q;
    berr_d = 1'b0;
    if (en) begin
      case (state_q)
        HUNT: begin
          lfsr_d = seed;
          phase_d = ~phase_q;
          // an all-zero seed would predict zeros forever, so reseed instead
          if (phase_q && seed != '0) begin
            state_d = VERIFY;
            run_d = '0;
          end
        end
        VERIFY: begin
          lfsr_d = seed;
          run_d = (din == pred) ? run_q + 8'd1 : 8'd0;
          if (din == pred && run_q + 8'd1 == LOCK_CNT[7:0]) begin
            state_d = LOCKED;
            bad_d = '0;
          end
        end
        LOCKED: begin
          lfsr_d = lfsr_adv;
          berr_d = pc != '0;
          bcnt_d = &bcnt_q ? bcnt_q : bcnt_q + 1'b1;
          err_d = |err_sum[ERR_W+3:ERR_W] ? '1 : err_sum[ERR_W-1:0];
          bad_d = (pc != '0) ? bad_q + 8'd1 : 8'd0;
          if (pc != '0 && bad_q + 8'd1 == UNLOCK_CNT[7:0]) begin
            state_d = HUNT;
            phase_d = 1'b0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (clear) begin
      err_d = '0;
      bcnt_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= HUNT;
      lfsr_q <= '0;
      phase_q <= 1'b0;
      run_q <= '0;
      bad_q <= '0;
      err_q <= '0;
      bcnt_q <= '0;
      berr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      phase_q <= phase_d;
      run_q <= run_d;
      bad_q <= bad_d;
      err_q <= err_d;
      bcnt_q <= bcnt_d;
      berr_q <= berr_d;
    end
  end

  assign locked = state_q == LOCKED;
  assign byte_err = berr_q;
  assign err_cnt = err_q;
  assign byte_cnt = bcnt_q;
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: randomized scoreboard bench against a bit-queue PRBS15 reference model.
module tb_prbs_checker;
  localparam int LC = 4;
  localparam int UC = 4;
  logic CLK = 0, RSTn = 0, en = 0, clear = 0;
  logic [7:0] din = 0;
  logic locked, byte_err, locked4, byte_err4;
  logic [15:0] err_cnt;
  logic [31:0] byte_cnt, bc4;
  logic [3:0] err4;

  always #5 CLK = ~CLK;

  prbs_checker #(.LOCK_CNT(LC), .UNLOCK_CNT(UC)) dut (
    .CLK(CLK), .RSTn(RSTn), .en(en), .din(din), .clear(clear),
    .locked(locked), .byte_err(byte_err), .err_cnt(err_cnt), .byte_cnt(byte_cnt));
  prbs_checker #(.ERR_W(4)) dut4 (
    .CLK(CLK), .RSTn(RSTn), .en(en), .din(din), .clear(clear),
    .locked(locked4), .byte_err(byte_err4), .err_cnt(err4), .byte_cnt(bc4));

  typedef bit bq_t[$];
  typedef struct {logic lk; logic be; logic [15:0] ec; logic [31:0] bc; logic [3:0] e4;} exp_t;
  exp_t exp_q[$];
  exp_t mx;
  int checks = 0, errors = 0;
  int ms, ph, run, bad;
  longint m_err, m_bc, m_e4;
  bit m_be;
  bq_t hist, gq;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  // next 8 sequence bits after the history q (front = oldest), first bit in bit 7
  function automatic logic [7:0] predict(input bq_t q);
    bq_t t = q;
    logic [7:0] r = 0;
    for (int i = 0; i < 8; i++) begin
      bit b = t[t.size()-14] ^ t[t.size()-15];
      r[7-i] = b;
      t.push_back(b);
      void'(t.pop_front());
    end
    return r;
  endfunction

  task automatic hist_push(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) hist.push_back(b[i]);
    while (hist.size() > 15) void'(hist.pop_front());
  endtask

  task automatic gen_next(output logic [7:0] b);
    b = predict(gq);
    for (int i = 7; i >= 0; i--) begin
      gq.push_back(b[i]);
      void'(gq.pop_front());
    end
  endtask

  task automatic model_reset();
    ms = 0; ph = 0; run = 0; bad = 0; m_be = 0;
    m_err = 0; m_bc = 0; m_e4 = 0;
    hist.delete();
    gq.delete();
    for (int i = 0; i < 15; i++) gq.push_back(1'b1);
    exp_q.delete();
  endtask

  task automatic model(input logic e, input logic [7:0] d, input logic c);
    logic [7:0] p;
    int pc;
    bit z;
    m_be = 0;
    if (e) begin
      if (ms == 0) begin
        hist_push(d);
        if (ph == 0) ph = 1;
        else begin
          ph = 0;
          z = 1;
          foreach (hist[i]) if (hist[i]) z = 0;
          if (!z) begin ms = 1; run = 0; end
        end
      end else if (ms == 1) begin
        p = predict(hist);
        if (d == p) begin
          run++;
          if (run == LC) begin ms = 2; bad = 0; end
        end else run = 0;
        hist_push(d);
      end else begin
        p = predict(hist);
        pc = $countones(d ^ p);
        m_be = pc != 0;
        if (!c) begin
          if (m_bc < 64'hFFFF_FFFF) m_bc++;
          m_err = (m_err + pc > 65535) ? 65535 : m_err + pc;
          m_e4 = (m_e4 + pc > 15) ? 15 : m_e4 + pc;
        end
        bad = (pc != 0) ? bad + 1 : 0;
        if (bad == UC) begin ms = 0; ph = 0; end
        hist_push(p);
      end
    end
    if (c) begin m_err = 0; m_bc = 0; m_e4 = 0; end
    exp_q.push_back('{lk: ms == 2, be: m_be, ec: m_err[15:0], bc: m_bc[31:0], e4: m_e4[3:0]});
  endtask

  task automatic cyc(input logic e, input logic [7:0] d, input logic c);
    en = e; din = d; clear = c;
    @(posedge CLK);
    model(e, d, c);
    #1;
  endtask

  task automatic send(input logic e, input logic [7:0] mask, input logic c);
    logic [7:0] d;
    if (e) begin gen_next(d); d = d ^ mask; end
    else d = 8'($urandom);
    cyc(e, d, c);
  endtask

  task automatic async_rst();
    en = 0; clear = 0;
    @(negedge CLK);
    #2 RSTn = 0;
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_byte_err", byte_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    model_reset();
    @(posedge CLK);
    #3 RSTn = 1;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      chk("sb_locked", locked, mx.lk);
      chk("sb_byte_err", byte_err, mx.be);
      chk("sb_err_cnt", err_cnt, mx.ec);
      chk("sb_byte_cnt", byte_cnt, mx.bc);
      chk("sb_err4", err4, mx.e4);
      chk("sb_locked4", locked4, mx.lk);
    end
  end

  initial begin
    bit seen;
    int n;
    model_reset();
    #3;
    chk("init_locked", locked, 0);
    chk("init_err_cnt", err_cnt, 0);
    chk("init_byte_cnt", byte_cnt, 0);
    chk("init_byte_err", byte_err, 0);
    #9 RSTn = 1;
    // clean lock: locked visible right after valid byte 6
    for (int i = 1; i <= 6; i++) begin
      send(1, 0, 0);
      chk("lock_timing", locked, i == 6);
    end
    repeat (100) send(1, 0, 0);
    chk("clean_byte_cnt", byte_cnt, 100);
    chk("clean_err_cnt", err_cnt, 0);
    // single-bit error
    send(1, 8'h08, 0);
    chk("single_byte_err", byte_err, 1);
    chk("single_err_cnt", err_cnt, 1);
    repeat (10) send(1, 0, 0);
    chk("single_err_hold", err_cnt, 1);
    chk("single_locked", locked, 1);
    // burst and unlock
    cyc(0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      send(1, 8'hFF, 0);
      chk("burst_locked", locked, i < 4);
    end
    chk("burst_err_cnt", err_cnt, 32);
    for (int i = 1; i <= 6; i++) send(1, 0, 0);
    chk("relock", locked, 1);
    chk("relock_err_cnt", err_cnt, 32);
    // saturation of the 4-bit counter
    cyc(0, 0, 1);
    repeat (3) send(1, 8'hFF, 0);
    chk("sat_err4", err4, 15);
    chk("sat_err16", err_cnt, 24);
    chk("sat_locked", locked, 1);
    repeat (3) send(1, 0, 0);
    // randomized gaps, rare single-bit errors, occasional clear
    repeat (400) send($urandom_range(0, 2) != 0,
                      ($urandom_range(0, 15) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
                      $urandom_range(0, 39) == 0);
    n = 0;
    while (!locked && n < 20) begin send(1, 0, 0); n++; end
    chk("pre_clear_locked", locked, 1);
    send(1, 8'h21, 1);
    chk("clear_err_cnt", err_cnt, 0);
    chk("clear_byte_cnt", byte_cnt, 0);
    chk("clear_byte_err", byte_err, 1);
    // async reset mid-LOCKED, then relock with clean-lock timing
    async_rst();
    for (int i = 1; i <= 6; i++) begin
      send(1, 0, 0);
      chk("rst_relock_timing", locked, i == 6);
    end
    // gapped valid: same lock timing counted in valid bytes
    async_rst();
    for (int i = 1; i <= 6; i++) begin
      send(1, 0, 0);
      chk("gap_lock_timing", locked, i == 6);
      send(0, 0, 0);
      chk("gap_idle_byte_err", byte_err, 0);
    end
    // dead link: all-zero stream never locks
    async_rst();
    seen = 0;
    repeat (50) begin
      cyc(1, 8'h00, 0);
      if (locked) seen = 1;
    end
    chk("zeros_never_locked", seen, 0);
    cyc(0, 0, 0);
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side checker for the byte-wide PRBS15 stream produced by the team's PRBS generator; sits directly downstream and consumes its 8-bit output.
- Self-synchronises a local LFSR to the incoming stream and declares lock after a run of clean bytes.
- Once locked, counts checked bytes and bit errors so that software can compute the bit error rate (BER).

Parameters:
- LOCK_CNT, 4: consecutive error-free bytes in VERIFY needed to enter LOCKED (range 1..255).
- UNLOCK_CNT, 4: consecutive errored bytes in LOCKED that force a return to HUNT (range 1..255).
- ERR_W, 16: width of the bit-error counter.
- BYTE_W, 32: width of the checked-byte counter.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  reset.
- en  in  1  din valid this cycle.
- din  in  8  eight consecutive sequence bits; din[7] is the oldest.
- clear  in  1  synchronous clear of err_cnt and byte_cnt only.
- locked  out  1  checker is in LOCKED.
- byte_err  out  1  pulse: the previous valid byte, checked in LOCKED, had at least one bit error.
- err_cnt  out  ERR_W  saturating count of bit errors.
- byte_cnt  out  BYTE_W  saturating count of bytes checked in LOCKED.

Behaviour:
- Reset RSTn is asynchronous, active-low; clock CLK. All state is reset; locked=0, byte_err=0, err_cnt=0, byte_cnt=0, state=HUNT, LFSR=0, run counters=0.
- Sequence definition: s[k] = s[k-14] XOR s[k-15] (PRBS15, x^15+x^14+1). The LFSR holds the last 15 bits. The predicted byte is the next 8 bits, obtained by unrolling the recurrence 8 times, oldest bit in bit 7.
- All outputs are registered and reflect a valid byte on the cycle after it arrives. When en=0, nothing changes and byte_err=0.
- HUNT:
  - The first valid byte is shifted into the LFSR; stay in HUNT.
  - The second valid byte is shifted in; the LFSR now holds the 15 newest bits. Go to VERIFY with the clean-run counter = 0.
  - The seed phase is counted with a 1-bit phase flag.
- VERIFY:
  - Compare din against the predicted byte.
  - Match: clean-run counter +1. When it reaches LOCK_CNT, go to LOCKED; locked=1 on the following cycle.
  - Mismatch: clean-run counter = 0; stay in VERIFY.
  - The LFSR is always loaded from the received din (self-synchronising), so one erroneous byte only delays lock.
  - No counting and no byte_err in this state.
- LOCKED:
  - The LFSR free-runs on predicted bits; received data never reloads it, so a single bit error counts exactly once.
  - byte_cnt +1 per valid byte.
  - err_cnt += popcount(din XOR predicted), a value from 0 to 8.
  - byte_err = (popcount != 0).
  - The bad-run counter increments on an errored byte and resets to 0 on a clean byte. When it reaches UNLOCK_CNT, go to HUNT and clear the LFSR phase; locked=0 on the next cycle.
  - The errors of the bytes that triggered unlock are counted.
- Saturation: err_cnt and byte_cnt stick at their all-ones value. When err_cnt is near its maximum, the addition clamps to all-ones rather than wrapping.
- Clear:
  - clear=1 zeroes both counters and takes priority over a simultaneous count; the current byte's errors and count are discarded.
  - clear does not affect state, LFSR or locked.
  - clear is legal when en=0.
- Stream all zeros: a zero seed predicts zeros forever. HUNT therefore rejects a seed of all zeros (stays in HUNT and reseeds), so locked never asserts on a dead link.
- Reset mid-operation: immediate return to HUNT with all counters cleared.

Decomposition:
- Package prbs_pkg:
  - PRBS15_LEN=15, TAP_A=14, TAP_B=15.
  - enum chk_state_t {HUNT, VERIFY, LOCKED}.
  - Function popcount8.
  - Shared with the generator so both sides use one polynomial definition.
- Sub-module prbs15_step8: purely combinational; input 15-bit state; outputs predicted byte and next 15-bit state. Reusable by the generator for byte-wide mode.

Test Plan:
- Clean lock: ideal PRBS15 stream from seed 15'h7FFF, en=1 every cycle. locked rises on the cycle after valid byte 2+LOCK_CNT (byte 6); after 100 further bytes, byte_cnt=100, err_cnt=0.
- Single-bit error: while locked, flip din[3] of one byte. One byte_err pulse one cycle later; err_cnt=1; err_cnt is not incremented on following bytes; locked stays 1.
- Burst and unlock: while locked, send 4 bytes each XORed with 8'hFF. err_cnt=32; locked falls after the 4th byte; after a clean stream, relock within 6 valid bytes with err_cnt still 32.
- Gapped valid with clear: en toggling 1-0-1 gives the same lock timing counted in valid bytes. Assert clear together with an errored byte: err_cnt=0 and byte_cnt=0 next cycle.
- Saturation and zeros: with ERR_W=4, inject 3 full-byte errors; err_cnt holds at 15. An all-zero din stream for 50 bytes never asserts locked.
- Async reset: assert RSTn low mid-LOCKED between clock edges. All outputs are 0 immediately; after release, relock follows the clean-lock timing.
